ahb_iopmp_mc: RTL and testbench

Parametrised multi-channel AHB I/O physical memory protection filter. It sits between NUM_CH bus-master slave ports and their downstream master ports. Each channel is checked against NUM_RGN base/mask regions that carry per-region read and write permissions. A denied access is blocked downstream and answered with a two-cycle AHB ERROR. The first violation per channel is captured, and a per-channel interrupt is raised. The block is configured through its own zero-wait-state AHB slave port.

---
 rtl/ahb_enum.sv | 44 ++++
 rtl/iopmp_chan.sv | 139 +++++++++++++
 rtl/ahb_iopmp_mc.sv | 201 ++++++++++++++++++++
 tb/tb_ahb_iopmp_mc.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_enum.sv
// Shared AHB encodings and I/O-PMP register layout types.
package ahb_enum;

  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    PASS = 2'd0,
    ERR1 = 2'd1,
    ERR2 = 2'd2
  } iopmp_state_t;

  // Region attribute word: bit0 enable, bit1 read, bit2 write.
  typedef struct packed {
    logic w;
    logic r;
    logic en;
  } iopmp_attr_t;

  // Captured violation info: bit0 hwrite, bits3:1 hsize, bits7:4 hprot.
  typedef struct packed {
    logic [3:0] hprot;
    logic [2:0] hsize;
    logic       hwrite;
  } iopmp_err_info_t;

  // Register map: per-channel blocks below RGN_AREA_BASE, region entries above.
  localparam logic [11:0] RGN_AREA_BASE = 12'h100;

  // Word offsets within a 16-byte block (haddr[3:2]).
  localparam logic [1:0] OFF_STATUS   = 2'd0;
  localparam logic [1:0] OFF_ERR_ADDR = 2'd1;
  localparam logic [1:0] OFF_ERR_INFO = 2'd2;
  localparam logic [1:0] OFF_BASE     = 2'd0;
  localparam logic [1:0] OFF_MASK     = 2'd1;
  localparam logic [1:0] OFF_ATTR     = 2'd2;

  // Flat region-entry index for a config offset inside the region area.
  function automatic logic [7:0] rgn_entry(input logic [11:0] off);
    return off[11:4] - RGN_AREA_BASE[11:4];
  endfunction

endpackage

// File: rtl/iopmp_chan.sv
// One filtered AHB channel: region match, error FSM, violation capture/count.
module iopmp_chan
  import ahb_enum::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_RGN    = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_RGN-1:0][ADDR_WIDTH-1:0]  rgn_base,
  input  logic [NUM_RGN-1:0][ADDR_WIDTH-1:0]  rgn_mask,
  input  iopmp_attr_t [NUM_RGN-1:0]           rgn_attr,
  input  logic                                clr_vld,
  input  logic                                clr_cnt,
  input  logic [ADDR_WIDTH-1:0]               s_haddr,
  input  logic [3:0]                          s_hprot,
  input  logic [2:0]                          s_hsize,
  input  logic [1:0]                          s_htrans,
  input  logic [2:0]                          s_hburst,
  input  logic                                s_hwrite,
  input  logic [DATA_WIDTH-1:0]               s_hwdata,
  output logic [1:0]                          s_hresp,
  output logic                                s_hready,
  output logic                                s_hgrant,
  output logic [DATA_WIDTH-1:0]               s_hrdata,
  output logic [ADDR_WIDTH-1:0]               m_haddr,
  output logic [3:0]                          m_hprot,
  output logic [2:0]                          m_hsize,
  output logic [1:0]                          m_htrans,
  output logic [2:0]                          m_hburst,
  output logic                                m_hwrite,
  output logic [DATA_WIDTH-1:0]               m_hwdata,
  input  logic [1:0]                          m_hresp,
  input  logic                                m_hready,
  input  logic                                m_hgrant,
  input  logic [DATA_WIDTH-1:0]               m_hrdata,
  output logic                                err_vld,
  output logic [7:0]                          viol_cnt,
  output logic [7:0]                          hit_idx,
  output logic [ADDR_WIDTH-1:0]               err_addr,
  output iopmp_err_info_t                     err_info
);

  iopmp_state_t state;
  logic         hit;
  logic         allowed;
  logic [7:0]   match_idx;
  logic         take;
  logic         viol;

  assign m_haddr  = s_haddr;
  assign m_hprot  = s_hprot;
  assign m_hsize  = s_hsize;
  assign m_hburst = s_hburst;
  assign m_hwrite = s_hwrite;
  assign m_hwdata = s_hwdata;
  assign s_hrdata = m_hrdata;
  assign s_hgrant = m_hgrant;

  // Lowest-index enabled region that matches decides the permission.
  always_comb begin
    hit       = 1'b0;
    allowed   = 1'b0;
    match_idx = '0;
    for (int unsigned i = 0; i < NUM_RGN; i++) begin
      if (!hit && rgn_attr[i].en && ((s_haddr & rgn_mask[i]) == rgn_base[i])) begin
        hit       = 1'b1;
        match_idx = 8'(i);
        allowed   = s_hwrite ? rgn_attr[i].w : rgn_attr[i].r;
      end
    end
  end

  assign take = (state == PASS) && s_htrans[1] && m_hready;
  assign viol = take && !allowed;

  // Pass-through in PASS; block downstream and drive the two-cycle ERROR otherwise.
  always_comb begin
    m_htrans = s_htrans;
    s_hready = m_hready;
    s_hresp  = m_hresp;
    case (state)
      PASS: begin
        if (viol) m_htrans = HTRANS_IDLE;
      end
      ERR1: begin
        m_htrans = HTRANS_IDLE;
        s_hready = 1'b0;
        s_hresp  = HRESP_ERROR;
      end
      default: begin
        m_htrans = HTRANS_IDLE;
        s_hready = 1'b1;
        s_hresp  = HRESP_ERROR;
      end
    endcase
  end

  // Error response sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PASS;
    end else begin
      case (state)
        PASS:    if (viol) state <= ERR1;
        ERR1:    state <= ERR2;
        default: state <= PASS;
      endcase
    end
  end

  // Violation capture, counter and last-hit tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_vld  <= 1'b0;
      viol_cnt <= '0;
      hit_idx  <= '0;
      err_addr <= '0;
      err_info <= '0;
    end else begin
      if (viol) begin
        // A W1C landing with a new violation is overridden: re-capture and stay valid.
        err_vld <= 1'b1;
        if (!err_vld || clr_vld) begin
          err_addr <= s_haddr;
          err_info <= {s_hprot, s_hsize, s_hwrite};
        end
        if (clr_cnt) viol_cnt <= 8'd1;
        else if (viol_cnt != 8'hFF) viol_cnt <= viol_cnt + 8'd1;
      end else begin
        if (clr_vld) err_vld <= 1'b0;
        if (clr_cnt) viol_cnt <= '0;
      end
      if (take && allowed) hit_idx <= match_idx;
    end
  end

endmodule

// File: rtl/ahb_iopmp_mc.sv
// Multi-channel AHB I/O-PMP filter: config slave port, region table, channel filters.
module ahb_iopmp_mc
  import ahb_enum::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned NUM_RGN    = 8
) (
  input  logic                               hclk,
  input  logic                               hreset,
  input  logic                               hsel,
  input  logic [ADDR_WIDTH-1:0]              haddr,
  input  logic [2:0]                         hsize,
  input  logic [1:0]                         htrans,
  input  logic                               hwrite,
  input  logic [DATA_WIDTH-1:0]              hwdata,
  output logic [1:0]                         hresp,
  output logic                               hready,
  output logic [DATA_WIDTH-1:0]              hrdata,
  input  logic [NUM_CH-1:0][ADDR_WIDTH-1:0]  s_haddr,
  input  logic [NUM_CH-1:0][3:0]             s_hprot,
  input  logic [NUM_CH-1:0][2:0]             s_hsize,
  input  logic [NUM_CH-1:0][1:0]             s_htrans,
  input  logic [NUM_CH-1:0][2:0]             s_hburst,
  input  logic [NUM_CH-1:0]                  s_hwrite,
  input  logic [NUM_CH-1:0][DATA_WIDTH-1:0]  s_hwdata,
  output logic [NUM_CH-1:0][1:0]             s_hresp,
  output logic [NUM_CH-1:0]                  s_hready,
  output logic [NUM_CH-1:0]                  s_hgrant,
  output logic [NUM_CH-1:0][DATA_WIDTH-1:0]  s_hrdata,
  output logic [NUM_CH-1:0][ADDR_WIDTH-1:0]  m_haddr,
  output logic [NUM_CH-1:0][3:0]             m_hprot,
  output logic [NUM_CH-1:0][2:0]             m_hsize,
  output logic [NUM_CH-1:0][1:0]             m_htrans,
  output logic [NUM_CH-1:0][2:0]             m_hburst,
  output logic [NUM_CH-1:0]                  m_hwrite,
  output logic [NUM_CH-1:0][DATA_WIDTH-1:0]  m_hwdata,
  input  logic [NUM_CH-1:0][1:0]             m_hresp,
  input  logic [NUM_CH-1:0]                  m_hready,
  input  logic [NUM_CH-1:0]                  m_hgrant,
  input  logic [NUM_CH-1:0][DATA_WIDTH-1:0]  m_hrdata,
  output logic [NUM_CH-1:0]                  irq
);

  localparam int unsigned NUM_ENT = NUM_CH * NUM_RGN;

  logic [NUM_ENT-1:0][ADDR_WIDTH-1:0] rgn_base;
  logic [NUM_ENT-1:0][ADDR_WIDTH-1:0] rgn_mask;
  iopmp_attr_t [NUM_ENT-1:0]          rgn_attr;
  logic [NUM_CH-1:0]                  ie;

  logic [NUM_CH-1:0]                  err_vld;
  logic [NUM_CH-1:0][7:0]             viol_cnt;
  logic [NUM_CH-1:0][7:0]             hit_idx;
  logic [NUM_CH-1:0][ADDR_WIDTH-1:0]  err_addr;
  iopmp_err_info_t [NUM_CH-1:0]       err_info;
  logic [NUM_CH-1:0]                  clr_vld;
  logic [NUM_CH-1:0]                  clr_cnt;
  logic [NUM_CH-1:0]                  ie_we;

  logic                               acc;
  logic [11:0]                        rd_off;
  logic [DATA_WIDTH-1:0]              rd_data;
  logic                               wr_pend;
  logic [11:0]                        wr_off;
  logic                               unused_cfg;

  assign hready     = 1'b1;
  assign hresp      = HRESP_OKAY;
  assign acc        = hsel && htrans[1];
  assign rd_off     = haddr[11:0];
  assign unused_cfg = ^{haddr[ADDR_WIDTH-1:12], hsize, htrans[0]};

  // Read mux over the address-phase offset; unmapped locations read as zero.
  always_comb begin
    rd_data = '0;
    if (rd_off < RGN_AREA_BASE) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (rd_off[7:4] == 4'(c)) begin
          case (rd_off[3:2])
            OFF_STATUS:   rd_data = {8'h00, hit_idx[c], viol_cnt[c], 7'h00, err_vld[c]};
            OFF_ERR_ADDR: rd_data = DATA_WIDTH'(err_addr[c]);
            OFF_ERR_INFO: rd_data = DATA_WIDTH'(err_info[c]);
            default:      rd_data = DATA_WIDTH'(ie[c]);
          endcase
        end
      end
    end else begin
      for (int unsigned e = 0; e < NUM_ENT; e++) begin
        if (rgn_entry(rd_off) == 8'(e)) begin
          case (rd_off[3:2])
            OFF_BASE: rd_data = DATA_WIDTH'(rgn_base[e]);
            OFF_MASK: rd_data = DATA_WIDTH'(rgn_mask[e]);
            OFF_ATTR: rd_data = DATA_WIDTH'(rgn_attr[e]);
            default:  rd_data = '0;
          endcase
        end
      end
    end
  end

  // Data-phase write strobes for per-channel status and interrupt enable.
  always_comb begin
    clr_cnt = '0;
    clr_vld = '0;
    ie_we   = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (wr_pend && (wr_off < RGN_AREA_BASE) && (wr_off[7:4] == 4'(c))) begin
        clr_cnt[c] = (wr_off[3:2] == OFF_STATUS);
        clr_vld[c] = (wr_off[3:2] == OFF_STATUS) && hwdata[0];
        ie_we[c]   = (wr_off[3:2] == 2'd3);
      end
    end
  end

  // Config port: register address phase, return read data one cycle later, level irq.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      wr_pend <= 1'b0;
      wr_off  <= '0;
      hrdata  <= '0;
      irq     <= '0;
    end else begin
      wr_pend <= acc && hwrite;
      wr_off  <= haddr[11:0];
      if (acc && !hwrite) hrdata <= rd_data;
      irq <= err_vld & ie;
    end
  end

  // Region table and interrupt enables, written in the data phase.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      rgn_base <= '0;
      rgn_mask <= '0;
      rgn_attr <= '0;
      ie       <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (ie_we[c]) ie[c] <= hwdata[0];
      end
      if (wr_pend && (wr_off >= RGN_AREA_BASE)) begin
        for (int unsigned e = 0; e < NUM_ENT; e++) begin
          if (rgn_entry(wr_off) == 8'(e)) begin
            case (wr_off[3:2])
              OFF_BASE: rgn_base[e] <= ADDR_WIDTH'(hwdata);
              OFF_MASK: rgn_mask[e] <= ADDR_WIDTH'(hwdata);
              OFF_ATTR: rgn_attr[e] <= iopmp_attr_t'(hwdata[2:0]);
              default:  ;
            endcase
          end
        end
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
    iopmp_chan #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_RGN    (NUM_RGN)
    ) u_chan (
      .clk      (hclk),
      .rst      (hreset),
      .rgn_base (rgn_base[c*NUM_RGN +: NUM_RGN]),
      .rgn_mask (rgn_mask[c*NUM_RGN +: NUM_RGN]),
      .rgn_attr (rgn_attr[c*NUM_RGN +: NUM_RGN]),
      .clr_vld  (clr_vld[c]),
      .clr_cnt  (clr_cnt[c]),
      .s_haddr  (s_haddr[c]),
      .s_hprot  (s_hprot[c]),
      .s_hsize  (s_hsize[c]),
      .s_htrans (s_htrans[c]),
      .s_hburst (s_hburst[c]),
      .s_hwrite (s_hwrite[c]),
      .s_hwdata (s_hwdata[c]),
      .s_hresp  (s_hresp[c]),
      .s_hready (s_hready[c]),
      .s_hgrant (s_hgrant[c]),
      .s_hrdata (s_hrdata[c]),
      .m_haddr  (m_haddr[c]),
      .m_hprot  (m_hprot[c]),
      .m_hsize  (m_hsize[c]),
      .m_htrans (m_htrans[c]),
      .m_hburst (m_hburst[c]),
      .m_hwrite (m_hwrite[c]),
      .m_hwdata (m_hwdata[c]),
      .m_hresp  (m_hresp[c]),
      .m_hready (m_hready[c]),
      .m_hgrant (m_hgrant[c]),
      .m_hrdata (m_hrdata[c]),
      .err_vld  (err_vld[c]),
      .viol_cnt (viol_cnt[c]),
      .hit_idx  (hit_idx[c]),
      .err_addr (err_addr[c]),
      .err_info (err_info[c])
    );
  end

endmodule

// File: tb/tb_ahb_iopmp_mc.sv
// Directed scoreboard bench for ahb_iopmp_mc (2 channels x 8 regions).
module tb_ahb_iopmp_mc;

  localparam int unsigned AW = 32, DW = 32, NCH = 2, NRGN = 8;

  logic                     hclk = 1'b0;
  logic                     hreset;
  logic                     hsel;
  logic [AW-1:0]            haddr;
  logic [2:0]               hsize;
  logic [1:0]               htrans;
  logic                     hwrite;
  logic [DW-1:0]            hwdata;
  logic [1:0]               hresp;
  logic                     hready;
  logic [DW-1:0]            hrdata;
  logic [NCH-1:0][AW-1:0]   s_haddr;
  logic [NCH-1:0][3:0]      s_hprot;
  logic [NCH-1:0][2:0]      s_hsize;
  logic [NCH-1:0][1:0]      s_htrans;
  logic [NCH-1:0][2:0]      s_hburst;
  logic [NCH-1:0]           s_hwrite;
  logic [NCH-1:0][DW-1:0]   s_hwdata;
  logic [NCH-1:0][1:0]      s_hresp;
  logic [NCH-1:0]           s_hready;
  logic [NCH-1:0]           s_hgrant;
  logic [NCH-1:0][DW-1:0]   s_hrdata;
  logic [NCH-1:0][AW-1:0]   m_haddr;
  logic [NCH-1:0][3:0]      m_hprot;
  logic [NCH-1:0][2:0]      m_hsize;
  logic [NCH-1:0][1:0]      m_htrans;
  logic [NCH-1:0][2:0]      m_hburst;
  logic [NCH-1:0]           m_hwrite;
  logic [NCH-1:0][DW-1:0]   m_hwdata;
  logic [NCH-1:0][1:0]      m_hresp;
  logic [NCH-1:0]           m_hready;
  logic [NCH-1:0]           m_hgrant;
  logic [NCH-1:0][DW-1:0]   m_hrdata;
  logic [NCH-1:0]           irq;

  int n_tests = 0;
  int n_fail  = 0;
  string       tq[$];
  logic [31:0] vq[$];

  ahb_iopmp_mc #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_CH     (NCH),
    .NUM_RGN    (NRGN)
  ) dut (
    .hclk (hclk), .hreset (hreset),
    .hsel (hsel), .haddr (haddr), .hsize (hsize), .htrans (htrans),
    .hwrite (hwrite), .hwdata (hwdata),
    .hresp (hresp), .hready (hready), .hrdata (hrdata),
    .s_haddr (s_haddr), .s_hprot (s_hprot), .s_hsize (s_hsize),
    .s_htrans (s_htrans), .s_hburst (s_hburst), .s_hwrite (s_hwrite),
    .s_hwdata (s_hwdata),
    .s_hresp (s_hresp), .s_hready (s_hready), .s_hgrant (s_hgrant),
    .s_hrdata (s_hrdata),
    .m_haddr (m_haddr), .m_hprot (m_hprot), .m_hsize (m_hsize),
    .m_htrans (m_htrans), .m_hburst (m_hburst), .m_hwrite (m_hwrite),
    .m_hwdata (m_hwdata),
    .m_hresp (m_hresp), .m_hready (m_hready), .m_hgrant (m_hgrant),
    .m_hrdata (m_hrdata),
    .irq (irq)
  );

  always #5 hclk = ~hclk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    tq.push_back(tag);
    vq.push_back(v);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    string       tag;
    logic [31:0] exp;
    n_tests++;
    if (vq.size() == 0) begin
      n_fail++;
      $error("FAIL sb_underflow: observed %h required a queued entry", obs);
    end else begin
      tag = tq.pop_front();
      exp = vq.pop_front();
      assert (obs === exp) else begin
        n_fail++;
        $error("FAIL %s: observed %h required %h", tag, obs, exp);
      end
    end
  endtask

  task automatic cfg_write(input logic [31:0] addr, input logic [31:0] data);
    haddr = addr; hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1;
    step();
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = data;
    step();
  endtask

  task automatic cfg_read(input logic [31:0] addr, input logic [31:0] mask,
                          input logic [31:0] exp, input string tag);
    haddr = addr; hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0;
    push(tag, exp);
    step();
    hsel = 1'b0; htrans = 2'b00;
    pop_check(hrdata & mask);
  endtask

  task automatic chan_deny(input int ch, input logic [31:0] addr, input logic wr, input bit track);
    s_haddr[ch] = addr; s_hwrite[ch] = wr; s_htrans[ch] = 2'b10;
    if (track) push("deny_m_htrans", 32'h0);
    #1;
    if (track) pop_check(32'(m_htrans[ch]));
    step();
    s_htrans[ch] = 2'b00;
    if (track) begin push("err1_hready", 32'h0); push("err1_hresp", 32'h1); end
    #1;
    if (track) begin pop_check(32'(s_hready[ch])); pop_check(32'(s_hresp[ch])); end
    step();
    s_htrans[ch] = 2'b10;
    if (track) begin push("err2_hready", 32'h1); push("err2_hresp", 32'h1); push("err2_drop", 32'h0); end
    #1;
    if (track) begin
      pop_check(32'(s_hready[ch])); pop_check(32'(s_hresp[ch])); pop_check(32'(m_htrans[ch]));
    end
    s_htrans[ch] = 2'b00;
    step();
  endtask

  task automatic chan_pass(input int ch, input logic [31:0] addr, input logic wr);
    s_haddr[ch] = addr; s_hwrite[ch] = wr; s_htrans[ch] = 2'b10;
    push("pass_m_htrans", 32'h2); push("pass_m_haddr", addr); push("pass_s_hready", 32'h1);
    #1;
    pop_check(32'(m_htrans[ch])); pop_check(m_haddr[ch]); pop_check(32'(s_hready[ch]));
    step();
    s_htrans[ch] = 2'b00;
  endtask

  initial begin
    int sz;
    hreset = 1'b1; hsel = 1'b0; haddr = '0; hsize = 3'b010; htrans = 2'b00;
    hwrite = 1'b0; hwdata = '0;
    s_haddr = '0; s_hprot = {4'h3, 4'h3}; s_hsize = {3'b010, 3'b010}; s_htrans = '0;
    s_hburst = '0; s_hwrite = '0; s_hwdata = '0;
    m_hresp = '0; m_hready = '1; m_hgrant = 2'b01;
    m_hrdata[0] = 32'hA5A5_5A5A; m_hrdata[1] = 32'h0000_1111;
    repeat (3) step();
    hreset = 1'b0;
    step();

    // Reset state and pass-through wiring
    push("rst_irq", 0);      pop_check(32'(irq));
    push("rst_hrdata", 0);   pop_check(hrdata);
    push("cfg_hready", 1);   pop_check(32'(hready));
    push("cfg_hresp", 0);    pop_check(32'(hresp));
    push("s_hgrant", 32'h1); pop_check(32'(s_hgrant));
    push("s_hrdata0", 32'hA5A5_5A5A); pop_check(s_hrdata[0]);

    // No regions: everything denied
    chan_deny(0, 32'h2000_0000, 1'b0, 1'b1);
    cfg_read(32'h004, '1, 32'h2000_0000, "t1_err_addr");
    cfg_read(32'h000, '1, 32'h0000_0101, "t1_status");
    cfg_read(32'h008, '1, 32'h0000_0034, "t1_err_info");
    cfg_write(32'h000, 32'h1);
    cfg_read(32'h000, '1, 32'h0, "t1_status_clr");

    // Region 0 read-only
    cfg_write(32'h100, 32'h2000_0000);
    cfg_write(32'h104, 32'hFFFF_0000);
    cfg_write(32'h108, 32'h3);
    chan_pass(0, 32'h2000_1234, 1'b0);
    cfg_read(32'h000, '1, 32'h0, "t2_status_pass");
    chan_deny(0, 32'h2000_1234, 1'b1, 1'b1);
    cfg_read(32'h008, '1, 32'h0000_0035, "t2_err_info");
    cfg_read(32'h000, '1, 32'h0000_0101, "t2_status");
    cfg_write(32'h000, 32'h1);

    // Overlapping regions: lowest index decides
    cfg_write(32'h100, 32'h3000_0000);
    cfg_write(32'h110, 32'h3000_0000);
    cfg_write(32'h114, 32'hFFFF_0000);
    cfg_write(32'h118, 32'h7);
    chan_deny(0, 32'h3000_0040, 1'b1, 1'b1);
    cfg_read(32'h000, '1, 32'h0000_0101, "t3_status_deny");
    cfg_write(32'h000, 32'h1);
    cfg_write(32'h108, 32'h0);
    chan_pass(0, 32'h3000_0040, 1'b1);
    cfg_read(32'h000, '1, 32'h0001_0000, "t3_status_hit1");
    cfg_read(32'h118, '1, 32'h7, "t3_attr1");

    // First capture sticks, counter accumulates
    chan_deny(0, 32'h0000_0010, 1'b0, 1'b1);
    chan_deny(0, 32'h0000_0020, 1'b0, 1'b1);
    cfg_read(32'h004, '1, 32'h0000_0010, "t4_err_addr_first");
    cfg_read(32'h000, '1, 32'h0001_0201, "t4_status_cnt2");

    // W1C of err_vld coinciding with a new violation
    haddr = 32'h000; hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1;
    step();
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = 32'h1;
    s_haddr[0] = 32'h0000_0030; s_hwrite[0] = 1'b0; s_htrans[0] = 2'b10;
    push("t4_race_htrans", 0);
    #1;
    pop_check(32'(m_htrans[0]));
    step();
    s_htrans[0] = 2'b00;
    step();
    step();
    cfg_read(32'h004, '1, 32'h0000_0030, "t4_race_err_addr");
    cfg_read(32'h000, 32'h1, 32'h1, "t4_race_vld");

    // Channel 1 interrupt, channel 0 unaffected in the same cycle
    cfg_write(32'h01C, 32'h1);
    s_haddr[0] = 32'h3000_0080; s_hwrite[0] = 1'b0; s_htrans[0] = 2'b10;
    s_haddr[1] = 32'h4000_0000; s_hwrite[1] = 1'b0; s_htrans[1] = 2'b10;
    push("t5_ch0_htrans", 32'h2); push("t5_ch0_haddr", 32'h3000_0080); push("t5_ch1_htrans", 0);
    #1;
    pop_check(32'(m_htrans[0])); pop_check(m_haddr[0]); pop_check(32'(m_htrans[1]));
    step();
    s_htrans = '0;
    push("t5_irq_early", 0); push("t5_ch0_hready", 1); push("t5_ch1_hready", 0);
    #1;
    pop_check(32'(irq)); pop_check(32'(s_hready[0])); pop_check(32'(s_hready[1]));
    step();
    push("t5_irq", 32'h2);
    pop_check(32'(irq));
    step();
    cfg_read(32'h014, '1, 32'h4000_0000, "t5_ch1_err_addr");
    cfg_write(32'h010, 32'h1);
    push("t5_irq_hold", 32'h2); pop_check(32'(irq));
    step();
    push("t5_irq_clr", 0); pop_check(32'(irq));

    // Counter saturation
    cfg_write(32'h000, 32'h1);
    for (int i = 0; i < 300; i++) chan_deny(0, 32'h0000_8000 + 32'(i), 1'b0, 1'b0);
    cfg_read(32'h000, '1, 32'h0001_FF01, "t6_status_sat");
    cfg_read(32'hFFC, '1, 32'h0, "t6_unmapped_ffc");
    cfg_read(32'h0F0, '1, 32'h0, "t6_unmapped_ch15");
    cfg_read(32'h004, '1, 32'h0000_8000, "t6_err_addr_first");

    // Reset while in ERR1
    s_haddr[0] = 32'h7000_0000; s_hwrite[0] = 1'b0; s_htrans[0] = 2'b10;
    push("t7_deny_htrans", 0);
    #1;
    pop_check(32'(m_htrans[0]));
    step();
    s_htrans[0] = 2'b00; hreset = 1'b1;
    push("t7_err1_hready", 0);
    #1;
    pop_check(32'(s_hready[0]));
    step();
    push("t7_rst_hready", 1); push("t7_rst_hresp", 0); push("t7_rst_hrdata", 0); push("t7_rst_irq", 0);
    pop_check(32'(s_hready[0])); pop_check(32'(s_hresp[0])); pop_check(hrdata); pop_check(32'(irq));
    hreset = 1'b0;
    step();
    cfg_read(32'h118, '1, 32'h0, "t7_attr_cleared");
    cfg_read(32'h01C, '1, 32'h0, "t7_ie_cleared");
    cfg_read(32'h000, '1, 32'h0, "t7_status_cleared");

    sz = vq.size();
    push("sb_drained", 0);
    pop_check(32'(sz));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
